// File: rtl/aidc_lite_sched_pkg.sv
// Shared types and constants for the AIDC-Lite compression job sequencer.
package aidc_lite_sched_pkg;

    localparam int DEF_BLK_BYTES = 128;
    localparam int CMD_CH_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ch_state_e;

    typedef struct packed {
        logic [31:0]         src;
        logic [31:0]         dst;
        logic                mode;
        logic [CMD_CH_W-1:0] ch;
        logic                last;
    } blk_cmd_t;

endpackage

// File: rtl/aidc_lite_rr_arb.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner.
module aidc_lite_rr_arb #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic          grant_valid,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_oh    = '0;
        grant_idx   = '0;
        for (int off = 0; off < N; off++) begin
            for (int j = 0; j < N; j++) begin
                if (!grant_valid && req[j] && (j == (int'(ptr) + off) % N)) begin
                    grant_valid = 1'b1;
                    grant_oh[j] = 1'b1;
                    grant_idx   = IW'(j);
                end
            end
        end
    end

    // Move the pointer one past the granted requester when the grant is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            if (int'(grant_idx) == N - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/aidc_lite_comp_sched.sv
// Multi-channel job sequencer: splits jobs into block commands, interleaves
// them round-robin onto one registered valid/ready port and tracks completions.
module aidc_lite_comp_sched
    import aidc_lite_sched_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int BLK_BYTES = DEF_BLK_BYTES,
    parameter  int LEN_W     = 25,
    parameter  int MAX_OUT   = 4,
    parameter  int SIZE_W    = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*32-1:0]    ch_src_addr_i,
    input  logic [NUM_CH*32-1:0]    ch_dst_addr_i,
    input  logic [NUM_CH*LEN_W-1:0] ch_len_i,
    input  logic [NUM_CH-1:0]       ch_mode_i,
    input  logic [NUM_CH-1:0]       ch_start_i,
    output logic [NUM_CH-1:0]       ch_busy_o,
    output logic [NUM_CH-1:0]       ch_done_o,
    output logic [NUM_CH*32-1:0]    ch_bytes_o,
    output logic                    blk_valid_o,
    input  logic                    blk_ready_i,
    output logic [31:0]             blk_src_addr_o,
    output logic [31:0]             blk_dst_addr_o,
    output logic                    blk_mode_o,
    output logic [CH_W-1:0]         blk_ch_o,
    output logic                    blk_last_o,
    input  logic                    cmp_valid_i,
    input  logic [CH_W-1:0]         cmp_ch_i,
    input  logic [SIZE_W-1:0]       cmp_size_i,
    output logic                    err_o
);

    localparam int          OUT_W    = $clog2(MAX_OUT) + 1;
    localparam logic [31:0] BLK_STEP = 32'(BLK_BYTES);
    localparam logic [31:0] OFS_MASK = 32'(BLK_BYTES - 1);

    ch_state_e          state      [NUM_CH];
    ch_state_e          state_next [NUM_CH];
    logic [31:0]        src_cur    [NUM_CH];
    logic [31:0]        dst_cur    [NUM_CH];
    logic [31:0]        bytes      [NUM_CH];
    logic [LEN_W-1:0]   remaining  [NUM_CH];
    logic [OUT_W-1:0]   outstanding[NUM_CH];
    logic [OUT_W-1:0]   out_next   [NUM_CH];
    logic               mode_q     [NUM_CH];

    logic [NUM_CH-1:0]  pending;
    logic [NUM_CH-1:0]  acc_hit;
    logic [NUM_CH-1:0]  cmp_hit;
    logic [NUM_CH-1:0]  req;
    logic               accept;
    logic               can_issue;
    logic               err_next;

    logic               grant_valid;
    logic [NUM_CH-1:0]  grant_oh;
    logic [CH_W-1:0]    grant_idx;

    blk_cmd_t           cmd_q;
    blk_cmd_t           next_cmd;

    assign accept    = blk_valid_o && blk_ready_i;
    assign can_issue = !blk_valid_o || blk_ready_i;

    // Per-channel view of the held command, acceptances, legal completions and outstanding updates.
    always_comb begin
        err_next = cmp_valid_i;
        for (int i = 0; i < NUM_CH; i++) begin
            pending[i]  = blk_valid_o && (cmd_q.ch == CMD_CH_W'(i));
            acc_hit[i]  = accept && pending[i];
            cmp_hit[i]  = cmp_valid_i && (int'(cmp_ch_i) == i) &&
                          (state[i] == RUN || state[i] == DRAIN) &&
                          (outstanding[i] != '0);
            out_next[i] = outstanding[i] + OUT_W'(acc_hit[i]) - OUT_W'(cmp_hit[i]);
            if (cmp_hit[i]) begin
                err_next = 1'b0;
            end
        end
    end

    // Eligibility counts the command sitting in the output register so MAX_OUT is never exceeded.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            req[i] = can_issue && (state[i] == RUN) &&
                     (remaining[i] > LEN_W'(pending[i])) &&
                     ((outstanding[i] + OUT_W'(pending[i])) < OUT_W'(MAX_OUT));
        end
    end

    aidc_lite_rr_arb #(
        .N (NUM_CH)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .advance     (can_issue),
        .grant_valid (grant_valid),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx)
    );

    // Build the next command, skipping past the block being accepted from the same channel.
    always_comb begin
        next_cmd    = '0;
        next_cmd.ch = CMD_CH_W'(grant_idx);
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_oh[i]) begin
                next_cmd.src  = pending[i] ? src_cur[i] + BLK_STEP : src_cur[i];
                next_cmd.dst  = pending[i] ? dst_cur[i] + BLK_STEP : dst_cur[i];
                next_cmd.mode = mode_q[i];
                next_cmd.last = pending[i] ? (remaining[i] == LEN_W'(2))
                                           : (remaining[i] == LEN_W'(1));
            end
        end
    end

    // Output command register: loads a new grant whenever empty or being accepted, else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_valid_o <= 1'b0;
            cmd_q       <= '0;
        end else if (can_issue) begin
            blk_valid_o <= grant_valid;
            cmd_q       <= grant_valid ? next_cmd : '0;
        end
    end

    // Channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_next[i];
            end
        end
    end

    // Channel next-state logic and the busy/done status derived from the state.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_next[i] = state[i];
            case (state[i])
                IDLE, DONE: begin
                    if (ch_start_i[i]) begin
                        state_next[i] = RUN;
                    end
                end
                RUN: begin
                    if (acc_hit[i] && remaining[i] == LEN_W'(1)) begin
                        state_next[i] = DRAIN;
                    end else if (remaining[i] == '0) begin
                        state_next[i] = DONE;
                    end
                end
                DRAIN: begin
                    if (out_next[i] == '0) begin
                        state_next[i] = DONE;
                    end
                end
                default: state_next[i] = IDLE;
            endcase
            ch_busy_o[i]           = (state[i] == RUN) || (state[i] == DRAIN);
            ch_done_o[i]           = (state[i] == DONE);
            ch_bytes_o[i*32 +: 32] = bytes[i];
        end
    end

    // Channel datapath: job latch on start, cursor and counter updates on acceptance and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                src_cur[i]     <= '0;
                dst_cur[i]     <= '0;
                bytes[i]       <= '0;
                remaining[i]   <= '0;
                outstanding[i] <= '0;
                mode_q[i]      <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((state[i] == IDLE || state[i] == DONE) && ch_start_i[i]) begin
                    src_cur[i]     <= ch_src_addr_i[i*32 +: 32] & ~OFS_MASK;
                    dst_cur[i]     <= ch_dst_addr_i[i*32 +: 32] & ~OFS_MASK;
                    remaining[i]   <= ch_len_i[i*LEN_W +: LEN_W];
                    mode_q[i]      <= ch_mode_i[i];
                    bytes[i]       <= '0;
                    outstanding[i] <= '0;
                end else begin
                    if (acc_hit[i]) begin
                        remaining[i] <= remaining[i] - LEN_W'(1);
                        src_cur[i]   <= src_cur[i] + BLK_STEP;
                        dst_cur[i]   <= dst_cur[i] + BLK_STEP;
                    end
                    if (cmp_hit[i]) begin
                        bytes[i] <= bytes[i] + 32'(cmp_size_i);
                    end
                    outstanding[i] <= out_next[i];
                end
            end
        end
    end

    // Illegal completion pulse, one cycle after the offending strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else begin
            err_o <= err_next;
        end
    end

    assign blk_src_addr_o = cmd_q.src;
    assign blk_dst_addr_o = cmd_q.dst;
    assign blk_mode_o     = cmd_q.mode;
    assign blk_ch_o       = cmd_q.ch[CH_W-1:0];
    assign blk_last_o     = cmd_q.last;

endmodule

// File: tb/tb_aidc_lite_comp_sched.sv
// Directed bench for the AIDC-Lite job sequencer with hand-computed expectations.
module tb_aidc_lite_comp_sched;

    localparam int NUM_CH = 4;
    localparam int LEN_W  = 25;
    localparam int SIZE_W = 8;
    localparam int CH_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH*32-1:0]    ch_src_addr_i;
    logic [NUM_CH*32-1:0]    ch_dst_addr_i;
    logic [NUM_CH*LEN_W-1:0] ch_len_i;
    logic [NUM_CH-1:0]       ch_mode_i;
    logic [NUM_CH-1:0]       ch_start_i;
    logic [NUM_CH-1:0]       ch_busy_o;
    logic [NUM_CH-1:0]       ch_done_o;
    logic [NUM_CH*32-1:0]    ch_bytes_o;
    logic                    blk_valid_o;
    logic                    blk_ready_i;
    logic [31:0]             blk_src_addr_o;
    logic [31:0]             blk_dst_addr_o;
    logic                    blk_mode_o;
    logic [CH_W-1:0]         blk_ch_o;
    logic                    blk_last_o;
    logic                    cmp_valid_i;
    logic [CH_W-1:0]         cmp_ch_i;
    logic [SIZE_W-1:0]       cmp_size_i;
    logic                    err_o;

    int vectors     = 0;
    int miscompares = 0;

    aidc_lite_comp_sched #(
        .NUM_CH    (NUM_CH),
        .BLK_BYTES (128),
        .LEN_W     (LEN_W),
        .MAX_OUT   (4),
        .SIZE_W    (SIZE_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_src_addr_i  (ch_src_addr_i),
        .ch_dst_addr_i  (ch_dst_addr_i),
        .ch_len_i       (ch_len_i),
        .ch_mode_i      (ch_mode_i),
        .ch_start_i     (ch_start_i),
        .ch_busy_o      (ch_busy_o),
        .ch_done_o      (ch_done_o),
        .ch_bytes_o     (ch_bytes_o),
        .blk_valid_o    (blk_valid_o),
        .blk_ready_i    (blk_ready_i),
        .blk_src_addr_o (blk_src_addr_o),
        .blk_dst_addr_o (blk_dst_addr_o),
        .blk_mode_o     (blk_mode_o),
        .blk_ch_o       (blk_ch_o),
        .blk_last_o     (blk_last_o),
        .cmp_valid_i    (cmp_valid_i),
        .cmp_ch_i       (cmp_ch_i),
        .cmp_size_i     (cmp_size_i),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ch_src_addr_i = '0;
        ch_dst_addr_i = '0;
        ch_len_i      = '0;
        ch_mode_i     = '0;
        ch_start_i    = '0;
        blk_ready_i   = 1'b0;
        cmp_valid_i   = 1'b0;
        cmp_ch_i      = '0;
        cmp_size_i    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic start_ch(input int ch, input logic [31:0] src, input logic [31:0] dst,
                            input logic [LEN_W-1:0] len, input logic mode);
        ch_src_addr_i[ch*32 +: 32]    = src;
        ch_dst_addr_i[ch*32 +: 32]    = dst;
        ch_len_i[ch*LEN_W +: LEN_W]   = len;
        ch_mode_i[ch]                 = mode;
        ch_start_i[ch]                = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({blk_valid_o, blk_last_o, blk_mode_o, err_o, ch_busy_o, ch_done_o} !== 10'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 0",
                     {blk_valid_o, blk_last_o, blk_mode_o, err_o, ch_busy_o, ch_done_o});
        end
        vectors++;
        if ({ch_bytes_o, blk_src_addr_o, blk_dst_addr_o, blk_ch_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got bytes=%h src=%h dst=%h expected 0",
                     ch_bytes_o, blk_src_addr_o, blk_dst_addr_o);
        end
    endtask

    task automatic test_single_job();
        logic [31:0] exp_src;
        logic [31:0] exp_dst;
        logic [7:0]  sizes [3];
        sizes[0] = 8'd40;
        sizes[1] = 8'd60;
        sizes[2] = 8'd128;
        do_reset();
        blk_ready_i = 1'b1;
        start_ch(0, 32'h1000_0000, 32'h2000_0005, 25'd3, 1'b0);
        step();
        ch_start_i = '0;
        vectors++;
        if ({ch_busy_o, ch_done_o, blk_valid_o} !== {4'b0001, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL single_start: got busy=%b done=%b valid=%b expected 0001/0000/0",
                     ch_busy_o, ch_done_o, blk_valid_o);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            exp_src = 32'h1000_0000 + 32'(k * 128);
            exp_dst = 32'h2000_0000 + 32'(k * 128);
            vectors++;
            if ({blk_valid_o, blk_src_addr_o, blk_dst_addr_o, blk_ch_o, blk_last_o, blk_mode_o}
                !== {1'b1, exp_src, exp_dst, 2'd0, (k == 2), 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL single_cmd%0d: got v=%b src=%h dst=%h ch=%0d last=%b expected src=%h dst=%h last=%b",
                         k, blk_valid_o, blk_src_addr_o, blk_dst_addr_o, blk_ch_o, blk_last_o,
                         exp_src, exp_dst, (k == 2));
            end
        end
        step();
        vectors++;
        if ({blk_valid_o, ch_busy_o[0], ch_done_o[0]} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL single_drain: got valid=%b busy=%b done=%b expected 0/1/0",
                     blk_valid_o, ch_busy_o[0], ch_done_o[0]);
        end
        for (int k = 0; k < 3; k++) begin
            cmp_valid_i = 1'b1;
            cmp_ch_i    = 2'd0;
            cmp_size_i  = sizes[k];
            step();
            cmp_valid_i = 1'b0;
            if (k < 2) begin
                vectors++;
                if (ch_done_o[0] !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL single_early_done%0d: got %b expected 0", k, ch_done_o[0]);
                end
            end
        end
        vectors++;
        if ({ch_done_o[0], ch_busy_o[0], err_o, ch_bytes_o[31:0]} !== {1'b1, 1'b0, 1'b0, 32'd228}) begin
            miscompares++;
            $display("[TB] FAIL single_done: got done=%b busy=%b err=%b bytes=%0d expected 1/0/0/228",
                     ch_done_o[0], ch_busy_o[0], err_o, ch_bytes_o[31:0]);
        end
    endtask

    task automatic test_round_robin();
        int          exp_ch;
        logic [31:0] exp_src;
        do_reset();
        blk_ready_i = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            start_ch(i, 32'h0001_0000 * 32'(i + 1), 32'h0800_0000 + 32'(i * 32'h1000), 25'd2, 1'b0);
        end
        step();
        ch_start_i = '0;
        vectors++;
        if (ch_busy_o !== 4'b1111) begin
            miscompares++;
            $display("[TB] FAIL rr_busy: got %b expected 1111", ch_busy_o);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            exp_ch  = k % 4;
            exp_src = 32'h0001_0000 * 32'(exp_ch + 1) + 32'((k / 4) * 128);
            vectors++;
            if ({blk_valid_o, blk_ch_o, blk_src_addr_o, blk_last_o}
                !== {1'b1, 2'(exp_ch), exp_src, (k >= 4)}) begin
                miscompares++;
                $display("[TB] FAIL rr_order%0d: got v=%b ch=%0d src=%h last=%b expected v=1 ch=%0d src=%h last=%b",
                         k, blk_valid_o, blk_ch_o, blk_src_addr_o, blk_last_o, exp_ch, exp_src, (k >= 4));
            end
        end
        step();
        vectors++;
        if (blk_valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rr_end: got valid=%b expected 0", blk_valid_o);
        end
    endtask

    task automatic test_max_outstanding();
        int          cnt;
        logic [31:0] seen_src;
        do_reset();
        blk_ready_i = 1'b1;
        start_ch(1, 32'h0A00_0000, 32'h0B00_0000, 25'd10, 1'b1);
        step();
        ch_start_i = '0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (blk_valid_o) cnt++;
        end
        vectors++;
        if (cnt !== 4) begin
            miscompares++;
            $display("[TB] FAIL maxout_count: got %0d commands expected 4", cnt);
        end
        cmp_valid_i = 1'b1;
        cmp_ch_i    = 2'd1;
        cmp_size_i  = 8'd100;
        step();
        cmp_valid_i = 1'b0;
        cnt      = 0;
        seen_src = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (blk_valid_o) begin
                cnt++;
                seen_src = blk_src_addr_o;
            end
        end
        vectors++;
        if (cnt !== 1) begin
            miscompares++;
            $display("[TB] FAIL maxout_refill: got %0d commands expected 1", cnt);
        end
        vectors++;
        if ({seen_src, ch_bytes_o[63:32], err_o} !== {32'h0A00_0200, 32'd100, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL maxout_fifth: got src=%h bytes=%0d err=%b expected 0a000200/100/0",
                     seen_src, ch_bytes_o[63:32], err_o);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        blk_ready_i = 1'b0;
        start_ch(0, 32'h3000_0000, 32'h4000_0000, 25'd4, 1'b0);
        step();
        ch_start_i = '0;
        step();
        for (int h = 0; h < 5; h++) begin
            vectors++;
            if ({blk_valid_o, blk_src_addr_o, blk_dst_addr_o, blk_ch_o, blk_last_o, blk_mode_o}
                !== {1'b1, 32'h3000_0000, 32'h4000_0000, 2'd0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL hold%0d: got v=%b src=%h dst=%h ch=%0d last=%b expected 1/30000000/40000000/0/0",
                         h, blk_valid_o, blk_src_addr_o, blk_dst_addr_o, blk_ch_o, blk_last_o);
            end
            if (h == 1) start_ch(2, 32'h5000_0000, 32'h6000_0000, 25'd1, 1'b1);
            if (h == 2) ch_start_i = '0;
            step();
        end
        vectors++;
        if (ch_busy_o !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL hold_busy: got %b expected 0101", ch_busy_o);
        end
        blk_ready_i = 1'b1;
        step();
        vectors++;
        if ({blk_valid_o, blk_ch_o, blk_src_addr_o, blk_dst_addr_o, blk_last_o, blk_mode_o}
            !== {1'b1, 2'd2, 32'h5000_0000, 32'h6000_0000, 1'b1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL release_ch2: got v=%b ch=%0d src=%h dst=%h last=%b mode=%b expected ch2 50000000 60000000 1 1",
                     blk_valid_o, blk_ch_o, blk_src_addr_o, blk_dst_addr_o, blk_last_o, blk_mode_o);
        end
        step();
        vectors++;
        if ({blk_valid_o, blk_ch_o, blk_src_addr_o, blk_last_o, blk_mode_o}
            !== {1'b1, 2'd0, 32'h3000_0080, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL release_ch0: got v=%b ch=%0d src=%h last=%b expected ch0 30000080 0",
                     blk_valid_o, blk_ch_o, blk_src_addr_o, blk_last_o);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        blk_ready_i = 1'b1;
        start_ch(3, 32'h0C00_0000, 32'h0D00_0000, 25'd0, 1'b0);
        step();
        ch_start_i = '0;
        vectors++;
        if ({ch_done_o[3], ch_busy_o[3], blk_valid_o} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL zero_run: got done=%b busy=%b valid=%b expected 0/1/0",
                     ch_done_o[3], ch_busy_o[3], blk_valid_o);
        end
        step();
        vectors++;
        if ({ch_done_o[3], ch_busy_o[3], blk_valid_o} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL zero_done: got done=%b busy=%b valid=%b expected 1/0/0",
                     ch_done_o[3], ch_busy_o[3], blk_valid_o);
        end
        cmp_valid_i = 1'b1;
        cmp_ch_i    = 2'd3;
        cmp_size_i  = 8'd50;
        step();
        cmp_valid_i = 1'b0;
        vectors++;
        if ({err_o, ch_bytes_o[127:96], ch_done_o[3]} !== {1'b1, 32'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL zero_err: got err=%b bytes=%0d done=%b expected 1/0/1",
                     err_o, ch_bytes_o[127:96], ch_done_o[3]);
        end
        step();
        vectors++;
        if (err_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_err_pulse: got err=%b expected 0", err_o);
        end
    endtask

    task automatic test_reset_mid_job();
        do_reset();
        blk_ready_i = 1'b0;
        start_ch(0, 32'h7000_0000, 32'h7100_0000, 25'd5, 1'b1);
        step();
        ch_start_i = '0;
        step();
        vectors++;
        if (blk_valid_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_pre: got valid=%b expected 1", blk_valid_o);
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({blk_valid_o, blk_last_o, blk_mode_o, err_o, ch_busy_o, ch_done_o,
             blk_src_addr_o, blk_dst_addr_o, blk_ch_o, ch_bytes_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrst_clear: got valid=%b busy=%b done=%b src=%h dst=%h expected all 0",
                     blk_valid_o, ch_busy_o, ch_done_o, blk_src_addr_o, blk_dst_addr_o);
        end
        rst = 1'b0;
        step();
        blk_ready_i = 1'b1;
        start_ch(0, 32'hFFFF_FF80, 32'h0000_1000, 25'd2, 1'b0);
        step();
        ch_start_i = '0;
        step();
        vectors++;
        if ({blk_valid_o, blk_src_addr_o, blk_dst_addr_o, blk_last_o}
            !== {1'b1, 32'hFFFF_FF80, 32'h0000_1000, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL wrap_first: got v=%b src=%h dst=%h last=%b expected 1/ffffff80/00001000/0",
                     blk_valid_o, blk_src_addr_o, blk_dst_addr_o, blk_last_o);
        end
        step();
        vectors++;
        if ({blk_valid_o, blk_src_addr_o, blk_dst_addr_o, blk_last_o}
            !== {1'b1, 32'h0000_0000, 32'h0000_1080, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL wrap_second: got v=%b src=%h dst=%h last=%b expected 1/00000000/00001080/1",
                     blk_valid_o, blk_src_addr_o, blk_dst_addr_o, blk_last_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        $display("[TB] starting aidc_lite_comp_sched directed tests");
        test_reset();
        test_single_job();
        test_round_robin();
        test_max_outstanding();
        test_backpressure();
        test_zero_len();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aidc_lite_comp_sched.md
Name: aidc_lite_comp_sched

Overview:
Multi-channel job sequencer for the AIDC-Lite compression datapath.
- Accepts up to NUM_CH independent jobs (src/dst base, length in blocks, mode) and splits each into BLK_BYTES-sized block commands.
- Round-robin interleaves those commands onto one valid/ready port feeding the block compressor/decompressor.
- Tracks per-block completions, accumulates compressed byte counts, and raises a per-channel level done.

Parameters:
NUM_CH, 4, number of job channels (>=1)
BLK_BYTES, 128, block size in bytes, power of two
LEN_W, 25, width of job length field (blocks)
MAX_OUT, 4, max outstanding (issued, not completed) blocks per channel, power of two
SIZE_W, 8, width of per-block result size (must hold BLK_BYTES)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ch_src_addr_i  in  NUM_CH*32  per-channel source byte address
ch_dst_addr_i  in  NUM_CH*32  per-channel destination byte address
ch_len_i  in  NUM_CH*LEN_W  per-channel length in blocks
ch_mode_i  in  NUM_CH  0=compress, 1=decompress
ch_start_i  in  NUM_CH  start pulse per channel
ch_busy_o  out  NUM_CH  channel has an active job
ch_done_o  out  NUM_CH  level; job finished
ch_bytes_o  out  NUM_CH*32  accumulated result bytes of current/last job
blk_valid_o  out  1  block command valid
blk_ready_i  in  1  downstream accepts command
blk_src_addr_o  out  32  block source address
blk_dst_addr_o  out  32  block destination slot address
blk_mode_o  out  1  mode of issuing channel
blk_ch_o  out  $clog2(NUM_CH) (min 1)  issuing channel id
blk_last_o  out  1  final block of that channel's job
cmp_valid_i  in  1  block completion strobe
cmp_ch_i  in  $clog2(NUM_CH)  completing channel id
cmp_size_i  in  SIZE_W  result bytes of completed block
err_o  out  1  one-cycle pulse on illegal completion

Behaviour:
- Reset: all outputs 0; all channels IDLE; RR pointer = 0; counters cleared. Reset mid-job aborts everything, including a held blk_valid_o.
- Per-channel FSM:
  - IDLE/DONE -> RUN on ch_start_i. Latch src/dst with low log2(BLK_BYTES) bits forced 0, latch len and mode. Clear outstanding and ch_bytes_o; clear ch_done_o; set ch_busy_o.
  - ch_start_i while RUN/DRAIN: ignored.
  - len=0: RUN -> DONE the next cycle with no block issued.
  - RUN -> DRAIN once the last block is accepted (remaining reaches 0).
  - DRAIN -> DONE when outstanding reaches 0. In DONE: ch_busy_o=0, ch_done_o=1, held until the next start.
- Eligibility: state RUN, remaining>0, outstanding<MAX_OUT.
- Arbitration: round-robin starting at the RR pointer. Evaluated only when the output register is empty or being accepted this cycle. After a grant, pointer = granted+1 mod NUM_CH.
- Issue path: registered. Grant in cycle N -> blk_valid_o in N+1. blk_* remain stable while blk_valid_o && !blk_ready_i. Back-to-back issue allowed, giving 1 command/cycle at full throughput.
- Per-channel bookkeeping on acceptance (valid&&ready):
  - remaining--, outstanding++.
  - src and dst cursors += BLK_BYTES, wrapping mod 2^32.
  - blk_last_o=1 when remaining was 1.
- Grant bookkeeping: the outstanding/remaining check counts the block held in the output register, so MAX_OUT is never exceeded.
- Completion (cmp_valid_i): if cmp_ch_i is in RUN/DRAIN with outstanding>0, then outstanding-- and ch_bytes_o += cmp_size_i (mod 2^32). Otherwise ignore it and pulse err_o the next cycle.
- cmp_ch_i >= NUM_CH: treated as illegal (err_o).
- Simultaneous acceptance and completion on the same channel: outstanding unchanged, remaining decremented, bytes added.
- Simultaneous start on several channels: all latched in the same cycle.

Decomposition:
- Package aidc_lite_sched_pkg:
  - ch_state_e enum {IDLE, RUN, DRAIN, DONE}
  - blk_cmd_t struct {src, dst, mode, ch, last}
  - default BLK_BYTES constant
- Sub-module aidc_lite_rr_arb: parametrised NUM_CH round-robin arbiter with req vector, advance enable and one-hot/index grant. Reused later by the AHB master mux.

Test Plan:
- NUM_CH=4, ch0 start src=0x1000_0000, dst=0x2000_0005, len=3, mode=0, ready=1 -> 3 commands.
  - src 0x1000_0000/0x80/0x100, dst 0x2000_0000/0x80/0x100; last on 3rd.
  - Completions 40,60,128 -> ch_bytes_o=228, ch_done_o=1 one cycle after 3rd completion.
- ch0..ch3 started together, len=2 each -> issue order ch0,1,2,3,0,1,2,3 with consecutive blk_valid_o cycles.
- MAX_OUT=4, ch1 len=10, no completions -> exactly 4 commands then blk_valid_o=0. One completion -> exactly one more command.
- ready=0 for 5 cycles with a command pending -> blk_* stable; new ch_start_i on ch2 does not alter the held command.
- len=0 on ch3 -> ch_done_o[3]=1 two cycles after start, no command. Completion for idle ch3 -> err_o pulse, ch_bytes_o unchanged.
- rst asserted mid-job with blk_valid_o=1 -> next cycle all outputs 0. A fresh start then behaves as after power-up. Source wrap: src=0xFFFF_FF80, len=2 -> 0xFFFF_FF80, 0x0000_0000.
